// File: rtl/vc_output_allocator.sv
// Wormhole output-channel allocator: one round-robin arbiter per output channel.
// Each output holds its grant for a whole packet and releases it after the owner's tail flit transfers.
module vc_output_allocator #(
  parameter int IN_N     = 5,
  parameter int OUT_M    = 5,
  parameter int IN_IDX_W = $clog2(IN_N)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IN_N*OUT_M-1:0]       req_i,
  input  logic [IN_N-1:0]             tail_i,
  input  logic [IN_N-1:0]             vld_i,
  input  logic [OUT_M-1:0]            oc_rdy_i,
  output logic [IN_N-1:0]             grant_o,
  output logic [OUT_M*IN_IDX_W-1:0]   sel_o,
  output logic [OUT_M-1:0]            sel_vld_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [OUT_M-1:0] ONE_M = {{(OUT_M-1){1'b0}}, 1'b1};

  state_t              state_q [OUT_M];
  state_t              state_d [OUT_M];
  logic [IN_IDX_W-1:0] owner_q [OUT_M];
  logic [IN_IDX_W-1:0] owner_d [OUT_M];
  logic [IN_IDX_W-1:0] ptr_q   [OUT_M];
  logic [IN_IDX_W-1:0] ptr_d   [OUT_M];

  logic [OUT_M-1:0]    req_low [IN_N];
  logic [IN_N-1:0]     owns;
  logic [IN_N-1:0]     taken;
  logic                found;
  logic [IN_IDX_W-1:0] win;

  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    if (s >= IN_N) s = s - IN_N;
    return s;
  endfunction

  // Only the lowest set output bit of each VC's request vector counts.
  always_comb begin
    for (int i = 0; i < IN_N; i++) begin
      req_low[i] = req_i[i*OUT_M +: OUT_M] & (~req_i[i*OUT_M +: OUT_M] + ONE_M);
    end
  end

  always_comb begin
    owns = '0;
    for (int o = 0; o < OUT_M; o++) begin
      if (state_q[o] == BUSY) owns[owner_q[o]] = 1'b1;
    end
  end

  // Outputs decide in index order; a VC won by a lower output is masked for the higher ones.
  always_comb begin
    taken = '0;
    found = 1'b0;
    win   = '0;
    for (int o = 0; o < OUT_M; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      win        = '0;
      case (state_q[o])
        IDLE: begin
          for (int k = 0; k < IN_N; k++) begin
            if (!found && req_low[wrap_idx(int'(ptr_q[o]), k)][o]
                && !owns[wrap_idx(int'(ptr_q[o]), k)]
                && !taken[wrap_idx(int'(ptr_q[o]), k)]) begin
              found = 1'b1;
              win   = IN_IDX_W'(wrap_idx(int'(ptr_q[o]), k));
            end
          end
          if (found) begin
            state_d[o] = BUSY;
            owner_d[o] = win;
            ptr_d[o]   = (win == IN_IDX_W'(IN_N-1)) ? '0 : win + IN_IDX_W'(1);
            taken[win] = 1'b1;
          end
        end
        BUSY: begin
          if (vld_i[owner_q[o]] && tail_i[owner_q[o]] && oc_rdy_i[o]) state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int o = 0; o < OUT_M; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < OUT_M; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    sel_o     = '0;
    sel_vld_o = '0;
    for (int o = 0; o < OUT_M; o++) begin
      if (state_q[o] == BUSY) begin
        sel_o[o*IN_IDX_W +: IN_IDX_W] = owner_q[o];
        sel_vld_o[o]                  = 1'b1;
      end
    end
  end

  assign grant_o = owns;

endmodule

// File: tb/tb_vc_output_allocator.sv
// Directed-vector bench for vc_output_allocator with hand-computed expectations.
module tb_vc_output_allocator;

  localparam int IN_N  = 5;
  localparam int OUT_M = 5;
  localparam int IW    = 3;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [IN_N*OUT_M-1:0] req_i;
  logic [IN_N-1:0]       tail_i;
  logic [IN_N-1:0]       vld_i;
  logic [OUT_M-1:0]      oc_rdy_i;
  logic [IN_N-1:0]       grant_o;
  logic [OUT_M*IW-1:0]   sel_o;
  logic [OUT_M-1:0]      sel_vld_o;

  int n_chk = 0;
  int n_err = 0;

  vc_output_allocator #(.IN_N(IN_N), .OUT_M(OUT_M), .IN_IDX_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .tail_i(tail_i), .vld_i(vld_i),
    .oc_rdy_i(oc_rdy_i), .grant_o(grant_o), .sel_o(sel_o), .sel_vld_o(sel_vld_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int vc, input logic [OUT_M-1:0] v);
    req_i[vc*OUT_M +: OUT_M] = v;
  endtask

  function automatic logic [IW-1:0] sel_of(input int o);
    return sel_o[o*IW +: IW];
  endfunction

  int exp_own [6] = '{0, 1, 4, 0, 1, 4};

  initial begin
    rst_i = 1'b1; req_i = '0; tail_i = '0; vld_i = '0; oc_rdy_i = '1;
    step(); step();
    chk("rst_grant", grant_o, 0);
    chk("rst_selvld", sel_vld_o, 0);
    chk("rst_sel", sel_o, 0);
    rst_i = 1'b0;
    step();

    // single request latency
    set_req(3, 5'b10000);
    step();
    chk("lat_grant", grant_o, 5'b01000);
    chk("lat_selvld", sel_vld_o, 5'b10000);
    chk("lat_sel4", sel_of(4), 3);
    set_req(3, 5'b0); vld_i = 5'b01000; tail_i = 5'b01000;
    step();
    chk("lat_rel_selvld", sel_vld_o, 0);
    chk("lat_rel_grant", grant_o, 0);
    vld_i = '0; tail_i = '0;

    // multi-hot request: lowest output only
    set_req(2, 5'b10100);
    step();
    chk("mh_selvld", sel_vld_o, 5'b00100);
    chk("mh_sel2", sel_of(2), 2);
    chk("mh_grant", grant_o, 5'b00100);
    step();
    chk("mh_selvld_hold", sel_vld_o, 5'b00100);
    set_req(2, 5'b0); vld_i = 5'b00100; tail_i = 5'b00100;
    step();
    chk("mh_rel", sel_vld_o, 0);
    vld_i = '0; tail_i = '0;

    // ptr[4] is still 4, so VC4 wins over VC0; then the pointer wraps to 0
    set_req(0, 5'b10000); set_req(4, 5'b10000);
    step();
    chk("p4_sel4", sel_of(4), 4);
    chk("p4_grant", grant_o, 5'b10000);
    vld_i = 5'b10000; tail_i = 5'b10000;
    step();
    chk("p4_bubble_selvld", sel_vld_o, 0);
    chk("p4_bubble_grant", grant_o, 0);
    vld_i = '0; tail_i = '0;
    step();
    chk("p4_wrap_sel4", sel_of(4), 0);
    chk("p4_wrap_grant", grant_o, 5'b00001);
    set_req(0, 5'b0); set_req(4, 5'b0); vld_i = 5'b00001; tail_i = 5'b00001;
    step();
    chk("p4_rel", sel_vld_o, 0);
    vld_i = '0; tail_i = '0;

    // exclusive ownership
    set_req(0, 5'b01000);
    step();
    chk("ex_own3", sel_vld_o, 5'b01000);
    set_req(0, 5'b00100); set_req(1, 5'b00100);
    step();
    chk("ex_selvld", sel_vld_o, 5'b01100);
    chk("ex_sel2", sel_of(2), 1);
    chk("ex_grant", grant_o, 5'b00011);
    step();
    chk("ex_sel3", sel_of(3), 0);
    chk("ex_selvld_hold", sel_vld_o, 5'b01100);
    set_req(0, 5'b0); set_req(1, 5'b0); vld_i = 5'b00011; tail_i = 5'b00011;
    step();
    chk("ex_rel", sel_vld_o, 0);
    vld_i = '0; tail_i = '0;

    // non-owner tail, then tail held off by backpressure
    set_req(1, 5'b00001);
    step();
    chk("bp_own", sel_vld_o, 5'b00001);
    chk("bp_sel0", sel_of(0), 1);
    set_req(1, 5'b0); vld_i = 5'b01000; tail_i = 5'b01000;
    step();
    chk("bp_nonowner", sel_vld_o, 5'b00001);
    vld_i = 5'b00010; tail_i = 5'b00010; oc_rdy_i = 5'b11110;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_hold", sel_vld_o, 5'b00001);
    end
    oc_rdy_i = '1;
    step();
    chk("bp_rel", sel_vld_o, 0);
    vld_i = '0; tail_i = '0;

    // async reset mid-packet; ptr[1] must return to 0 so VC2 beats VC4
    set_req(2, 5'b00010);
    step();
    chk("rs_own", sel_vld_o, 5'b00010);
    chk("rs_grant", grant_o, 5'b00100);
    set_req(2, 5'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("rs_async_grant", grant_o, 0);
    chk("rs_async_selvld", sel_vld_o, 0);
    #1 rst_i = 1'b0;
    set_req(2, 5'b00010); set_req(4, 5'b00010);
    step();
    chk("rs_regrant_sel1", sel_of(1), 2);
    chk("rs_regrant_grant", grant_o, 5'b00100);
    set_req(2, 5'b0); set_req(4, 5'b0); vld_i = 5'b00100; tail_i = 5'b00100;
    step();
    chk("rs_rel", sel_vld_o, 0);
    vld_i = '0; tail_i = '0;

    // round-robin over VCs 0,1,4 on output 2 with 3-flit packets
    set_req(0, 5'b00100); set_req(1, 5'b00100); set_req(4, 5'b00100);
    step();
    for (int p = 0; p < 6; p++) begin
      chk("rr_grant", grant_o, 32'(1) << exp_own[p]);
      chk("rr_sel2", sel_of(2), exp_own[p]);
      vld_i = IN_N'(1) << exp_own[p];
      step();
      step();
      tail_i = IN_N'(1) << exp_own[p];
      step();
      chk("rr_bubble", sel_vld_o, 0);
      vld_i = '0; tail_i = '0;
      step();
    end
    req_i = '0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
